fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port framebuffer RAM arbiter between display scanout and the CHIP-8 core. Display reads (fixed latency, always win) are served first. CPU read, write and sprite-XOR read-modify-write operations, plus an optional hardware clear, fill the idle RAM cycles. Sits between the display block's fbAddr/fbData port and the 512 x 16 framebuffer RAM.

## Interface
Parameters:
- ADDR_W, 9, framebuffer word address width (512 words = 128x64 hires)
- DATA_W, 16, framebuffer word width
- LORES_WORDS, 128, words cleared in lores mode (64x32)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- hires  in  1  resolution mode, sampled at clear start
- disp_req  in  1  display read request, address valid same cycle
- disp_addr  in  ADDR_W  display word address
- disp_data  out  DATA_W  RAM read data, valid when disp_valid=1
- disp_valid  out  1  registered copy of disp_req
- cpu_req  in  1  CPU operation request, level, held until accepted
- cpu_op  in  2  00 read, 01 write, 10 xor, 11 reserved (treated as read)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write / xor data
- cpu_busy  out  1  arbiter cannot accept a CPU op this cycle
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data (read) or old word (xor), valid with cpu_ack, held after
- cpu_collide  out  1  xor only: |(old & cpu_wdata); valid with cpu_ack, held after
- clr_req  in  1  start hardware clear (pulse)
- clr_busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address (combinational grant mux)
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, synchronous, one cycle after address

## Operation
- Reset: state IDLE. cpu_busy, cpu_ack, cpu_collide, disp_valid, clr_busy, ram_we = 0; cpu_rdata = 0; clear counter = 0.
- Grant: disp_req=1 always owns RAM that cycle (ram_we=0, ram_addr=disp_addr). The FSM issues its access only on cycles with disp_req=0; otherwise it stalls in place.
- disp_data = ram_rdata (combinational); disp_valid = disp_req delayed one cycle.
- States:
  - IDLE: cpu_busy=0. clr_req wins over a simultaneous cpu_req → CLR. cpu_req → latch op/addr/wdata, go to ISSUE.
  - ISSUE: on a free cycle: write → ram_we=1, go ACK. Read/xor → read, go CAPT.
  - CAPT: capture ram_rdata into cpu_rdata. Read → cpu_ack next cycle, IDLE. Xor → compute new=old^wdata and collide, go WB.
  - WB: on a free cycle write new, go ACK.
  - ACK: pulse cpu_ack, go IDLE.
  - CLR: on each free cycle write 0 at counter and increment. Last word = 511 if hires, else LORES_WORDS-1. After the last write, clr_busy falls and the FSM returns to IDLE.
- cpu_busy=1 in every state except IDLE. A cpu_req held during busy is accepted on the first IDLE cycle.
- CAPT needs no free cycle: ram_rdata belongs to the address issued in ISSUE even if display owns the current cycle.
- An xor is atomic: no other CPU op or clear interleaves between its read and write-back.

## Timing
- Display: request cycle N → data valid cycle N+1, never stalled.
- CPU write, no contention: accept N, write N+1, cpu_ack N+2.
- CPU read: accept N, read N+1, capture N+2, cpu_ack N+3.
- CPU xor: accept N, read N+1, capture N+2, write N+3, cpu_ack N+4.
- Each display request adds exactly one stall cycle to a pending ISSUE/WB/CLR step.
- Clear: 512 (hires) or 128 (lores) free cycles.
- rst_n asserted mid-operation aborts immediately: no further RAM writes. A partial xor/clear leaves RAM as already written.
- Address arithmetic wraps at 2^ADDR_W; the clear counter never exceeds its last word.

## Configuration
- FB_CLEAR_EN defined: the CLR state, counter and clr_req/clr_busy behave as above.
- Undefined: no clear logic. clr_req is ignored, clr_busy is tied 0, and the screen is cleared by CPU writes.

## Test plan
- Reset with rst_n=0 mid-xor → all outputs 0, ram_we=0 within the reset cycle, IDLE after release.
- CPU write 0xA5A5 @0x010, then read @0x010, no display traffic → acks at +2 and +3 cycles, cpu_rdata=0xA5A5.
- Word @0x020=0x0F0F; xor with 0x00FF → RAM=0x0FF0, cpu_rdata=0x0F0F, cpu_collide=1; xor 0xF000 on 0x0FF0 → collide=0.
- disp_req on every cycle of a CPU write's ISSUE, for 3 cycles → write delayed 3 cycles, every disp_valid/disp_data correct, ack follows.
- FB_CLEAR_EN, hires=1, clr_req with cpu_req same cycle → 512 zero writes, clr_busy 512 cycles with no display traffic, CPU op accepted after.
- FB_CLEAR_EN, hires=0, preloaded word @128 → 128 writes only (addresses 0..127), word @128 unchanged.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// Client-side bundle of the framebuffer arbiter: display scanout, CPU operations and clear control.
// master = display/CPU side, slave = arbiter side.
interface fb_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic              hires;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cpu_req;
    logic [1:0]        cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_collide;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output hires, disp_req, disp_addr, cpu_req, cpu_op, cpu_addr, cpu_wdata, clr_req,
        input  disp_data, disp_valid, cpu_busy, cpu_ack, cpu_rdata, cpu_collide, clr_busy
    );

    modport slave (
        input  hires, disp_req, disp_addr, cpu_req, cpu_op, cpu_addr, cpu_wdata, clr_req,
        output disp_data, disp_valid, cpu_busy, cpu_ack, cpu_rdata, cpu_collide, clr_busy
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads always win, CPU read/write/xor and the
// optional hardware clear (enabled by defining FB_CLEAR_EN) use the remaining free cycles.
module fb_arbiter #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LORES_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    fb_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    typedef enum logic [2:0] {StIdle, StIssue, StCapt, StWb, StAck, StClr} state_e;
    typedef enum logic [1:0] {OpRead, OpWrite, OpXor} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              collide_q, collide_d;
    logic              disp_valid_q;

    logic              ram_free;
    logic [ADDR_W-1:0] fsm_addr;
    logic              fsm_we;
    logic [DATA_W-1:0] fsm_wdata;

`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_hires_q, clr_hires_d;
    logic [ADDR_W-1:0] clr_last;

    assign clr_last = clr_hires_q ? {ADDR_W{1'b1}} : ADDR_W'(LORES_WORDS - 1);
`else
    logic unused_clr;
    assign unused_clr = bus.clr_req ^ bus.hires ^ (LORES_WORDS == 0);
`endif

    assign ram_free = ~bus.disp_req;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        collide_d = collide_q;
        fsm_addr  = addr_q;
        fsm_we    = 1'b0;
        fsm_wdata = wdata_q;
`ifdef FB_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
        clr_hires_d = clr_hires_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef FB_CLEAR_EN
                if (bus.clr_req) begin
                    clr_cnt_d   = '0;
                    clr_hires_d = bus.hires;
                    state_d     = StClr;
                end else
`endif
                if (bus.cpu_req) begin
                    // Reserved opcode 11 falls through to a plain read.
                    op_d    = (bus.cpu_op == 2'b01) ? OpWrite :
                              (bus.cpu_op == 2'b10) ? OpXor : OpRead;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                fsm_we = (op_q == OpWrite);
                if (ram_free) begin
                    state_d = (op_q == OpWrite) ? StAck : StCapt;
                end
            end
            StCapt: begin
                // Read data belongs to the ISSUE address even if display owns this cycle.
                rdata_d = ram_rdata_i;
                if (op_q == OpXor) begin
                    wdata_d   = ram_rdata_i ^ wdata_q;
                    collide_d = |(ram_rdata_i & wdata_q);
                    state_d   = StWb;
                end else begin
                    state_d = StAck;
                end
            end
            StWb: begin
                fsm_we = 1'b1;
                if (ram_free) begin
                    state_d = StAck;
                end
            end
            StAck: state_d = StIdle;
`ifdef FB_CLEAR_EN
            StClr: begin
                fsm_addr  = clr_cnt_q;
                fsm_we    = 1'b1;
                fsm_wdata = '0;
                if (ram_free) begin
                    if (clr_cnt_q == clr_last) begin
                        clr_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= OpRead;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            collide_q    <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            collide_q    <= collide_d;
            disp_valid_q <= bus.disp_req;
        end
    end

`ifdef FB_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q   <= '0;
            clr_hires_q <= 1'b0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            clr_hires_q <= clr_hires_d;
        end
    end

    assign bus.clr_busy = (state_q == StClr);
`else
    assign bus.clr_busy = 1'b0;
`endif

    assign ram_addr_o      = bus.disp_req ? bus.disp_addr : fsm_addr;
    assign ram_we_o        = fsm_we & ram_free;
    assign ram_wdata_o     = fsm_wdata;
    assign bus.disp_data   = ram_rdata_i;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.cpu_busy    = (state_q != StIdle);
    assign bus.cpu_ack     = (state_q == StAck);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_collide = collide_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed and randomised CPU/display traffic checked against a word-level
// memory model and a phase-by-phase op latency model.
module tb_fb_arbiter;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LORES_WORDS(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    // Framebuffer RAM, with a preload path used only while the DUT is held in reset.
    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int            we_cnt;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) we_cnt <= 0;
        else if (ram_we) we_cnt <= we_cnt + 1;
    end

    int            n_assert;
    int            n_fail;
    bit            last_dreq;
    logic [AW-1:0] last_daddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [AW-1:0] rnd_daddr();
        return {1'b1, 8'($urandom)};
    endfunction

    function automatic int mem_mismatch();
        int n = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Advance one cycle, check last cycle's display read, then drive this cycle's display input.
    task automatic step(input bit dreq, input logic [AW-1:0] daddr);
        @(posedge clk);
        #1;
        check("disp_valid", 32'(bus.disp_valid), 32'(last_dreq));
        if (last_dreq) check("disp_data", 32'(bus.disp_data), 32'(ref_mem[last_daddr]));
        bus.disp_req  = dreq;
        bus.disp_addr = daddr;
        last_dreq     = dreq;
        last_daddr    = daddr;
    endtask

    // One CPU op; dmask bit k = display request in cycle k (cycle 0 = request cycle).
    task automatic do_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [31:0] dmask, output int ack_cyc);
        int            n_ph;
        int            idx;
        bit            ph_ram [3];
        bit            dreq;
        bit            exp_ack;
        logic [AW-1:0] da;
        logic [DW-1:0] old;
        old    = ref_mem[a];
        ph_ram = '{1'b1, 1'b0, 1'b1};
        case (op)
            2'b01:   n_ph = 1;
            2'b10:   n_ph = 3;
            default: n_ph = 2;
        endcase
        step(dmask[0], rnd_daddr());
        bus.cpu_req   = 1'b1;
        bus.cpu_op    = op;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        #1;
        check("idle_not_busy", 32'(bus.cpu_busy), 0);
        idx     = 0;
        ack_cyc = -1;
        for (int k = 1; k <= 40 && ack_cyc < 0; k++) begin
            dreq = (k < 32) ? dmask[k] : 1'b0;
            da   = rnd_daddr();
            step(dreq, da);
            bus.cpu_req = 1'b0;
            exp_ack     = (idx == n_ph);
            #1;
            check("op_busy", 32'(bus.cpu_busy), 1);
            check("op_ack", 32'(bus.cpu_ack), 32'(exp_ack));
            if (dreq) begin
                check("disp_no_we", 32'(ram_we), 0);
                check("disp_owns_addr", 32'(ram_addr), 32'(da));
            end
            if (exp_ack) ack_cyc = k;
            else if (!(ph_ram[idx] && dreq)) idx++;
        end
        if (ack_cyc < 0) check("ack_timeout", 0, 1);
        case (op)
            2'b01: ref_mem[a] = wd;
            2'b10: begin
                check("xor_old_word", 32'(bus.cpu_rdata), 32'(old));
                check("xor_collide", 32'(bus.cpu_collide), 32'(|(old & wd)));
                ref_mem[a] = old ^ wd;
            end
            default: check("read_data", 32'(bus.cpu_rdata), 32'(old));
        endcase
        check("ram_word", 32'(mem[a]), 32'(ref_mem[a]));
    endtask

    int            c;
    int            we0;
    int            clr_cyc;
    int            ack;
    logic [DW-1:0] old_w;

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        last_dreq     = 1'b0;
        last_daddr    = '0;
        rst_n         = 1'b0;
        pre_en        = 1'b0;
        pre_addr      = '0;
        pre_data      = '0;
        bus.hires     = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_op    = 2'b00;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.clr_req   = 1'b0;

        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            pre_en     = 1'b1;
            pre_addr   = AW'(i);
            pre_data   = DW'($urandom);
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_en = 1'b0;

        check("rst_busy", 32'(bus.cpu_busy), 0);
        check("rst_ack", 32'(bus.cpu_ack), 0);
        check("rst_collide", 32'(bus.cpu_collide), 0);
        check("rst_rdata", 32'(bus.cpu_rdata), 0);
        check("rst_disp_valid", 32'(bus.disp_valid), 0);
        check("rst_clr_busy", 32'(bus.clr_busy), 0);
        check("rst_we", 32'(ram_we), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read back, no display traffic.
        do_op(2'b01, 9'h010, 16'hA5A5, 0, c);
        check("wr_latency", c, 2);
        do_op(2'b00, 9'h010, 16'h0000, 0, c);
        check("rd_latency", c, 3);
        check("rd_a5a5", 32'(bus.cpu_rdata), 'hA5A5);

        // Xor with and without collision.
        do_op(2'b01, 9'h020, 16'h0F0F, 0, c);
        do_op(2'b10, 9'h020, 16'h00FF, 0, c);
        check("xor_latency", c, 4);
        check("xor1_old", 32'(bus.cpu_rdata), 'h0F0F);
        check("xor1_collide", 32'(bus.cpu_collide), 1);
        check("xor1_ram", 32'(mem[9'h020]), 'h0FF0);
        do_op(2'b10, 9'h020, 16'hF000, 0, c);
        check("xor2_collide", 32'(bus.cpu_collide), 0);
        check("xor2_ram", 32'(mem[9'h020]), 'hFFF0);

        // Display owns the three cycles after accept: write slips by three.
        do_op(2'b01, 9'h030, 16'h5A5A, 32'h0000_000E, c);
        check("stall_wr_latency", c, 5);
        do_op(2'b11, 9'h030, 16'h0000, 0, c);
        check("rsvd_latency", c, 3);

        // Reset during the capture cycle of an xor: no write-back may follow.
        old_w = ref_mem[9'h040];
        step(1'b0, '0);
        bus.cpu_req   = 1'b1;
        bus.cpu_op    = 2'b10;
        bus.cpu_addr  = 9'h040;
        bus.cpu_wdata = 16'hFFFF;
        step(1'b0, '0);
        bus.cpu_req = 1'b0;
        step(1'b0, '0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.cpu_busy), 0);
        check("midrst_ack", 32'(bus.cpu_ack), 0);
        check("midrst_collide", 32'(bus.cpu_collide), 0);
        check("midrst_rdata", 32'(bus.cpu_rdata), 0);
        check("midrst_disp_valid", 32'(bus.disp_valid), 0);
        check("midrst_clr_busy", 32'(bus.clr_busy), 0);
        check("midrst_we", 32'(ram_we), 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_we_hold", 32'(ram_we), 0);
        rst_n     = 1'b1;
        last_dreq = 1'b0;
        step(1'b0, '0);
        #1;
        check("midrst_idle", 32'(bus.cpu_busy), 0);
        check("midrst_word", 32'(mem[9'h040]), 32'(old_w));

        // Random CPU ops in the low half, random display reads in the high half.
        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom), {1'b0, 8'($urandom)}, DW'($urandom), $urandom & $urandom, c);
        end
        check("rand_image", mem_mismatch(), 0);

`ifdef FB_CLEAR_EN
        // Hires clear wins over a simultaneous CPU write, which is served afterwards.
        we0     = we_cnt;
        clr_cyc = 0;
        ack     = -1;
        step(1'b0, '0);
        bus.clr_req   = 1'b1;
        bus.hires     = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_op    = 2'b01;
        bus.cpu_addr  = 9'h005;
        bus.cpu_wdata = 16'h1234;
        for (int k = 1; k <= 600 && ack < 0; k++) begin
            step(1'b0, '0);
            bus.clr_req = 1'b0;
            #1;
            if (bus.clr_busy) clr_cyc++;
            if (bus.cpu_ack) begin
                ack         = k;
                bus.cpu_req = 1'b0;
            end
        end
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        ref_mem[5] = 16'h1234;
        check("hclr_busy_cycles", clr_cyc, 512);
        check("hclr_ack_cycle", ack, 515);
        check("hclr_writes", we_cnt - we0, 513);
        check("hclr_image", mem_mismatch(), 0);

        // Lores clear stops at word 127; hires changing mid-clear must not matter.
        do_op(2'b01, 9'h080, 16'hBEEF, 0, c);
        do_op(2'b01, 9'h07F, 16'h1111, 0, c);
        we0     = we_cnt;
        clr_cyc = 0;
        step(1'b0, '0);
        bus.clr_req = 1'b1;
        bus.hires   = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            step(1'b0, '0);
            bus.clr_req = 1'b0;
            bus.hires   = 1'b1;
            #1;
            if (bus.clr_busy) clr_cyc++;
        end
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        check("lclr_busy_cycles", clr_cyc, 128);
        check("lclr_writes", we_cnt - we0, 128);
        check("lclr_word128", 32'(mem[9'h080]), 'hBEEF);
        check("lclr_word127", 32'(mem[9'h07F]), 0);
        check("lclr_idle", 32'(bus.cpu_busy), 0);
        check("lclr_image", mem_mismatch(), 0);
`else
        // Without the clear feature a clear request is ignored entirely.
        we0 = we_cnt;
        step(1'b0, '0);
        bus.clr_req = 1'b1;
        bus.hires   = 1'b1;
        step(1'b0, '0);
        bus.clr_req = 1'b0;
        #1;
        check("noclr_clr_busy", 32'(bus.clr_busy), 0);
        check("noclr_cpu_busy", 32'(bus.cpu_busy), 0);
        repeat (3) step(1'b0, '0);
        check("noclr_writes", we_cnt - we0, 0);
        do_op(2'b01, 9'h011, 16'h3C3C, 0, c);
        check("noclr_wr_latency", c, 2);
`endif
        check("final_image", mem_mismatch(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
